// File: rtl/mem_dist_pkg.sv
// Shared types and sizing helpers for the multi-port distributed scratch RAM.
package mem_dist_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } init_state_t;

  // Address width that never collapses to zero bits for tiny memories.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

  function automatic int unsigned num_lanes(input int unsigned width, input int unsigned byte_w);
    return (width + byte_w - 32'd1) / byte_w;
  endfunction

endpackage

// File: rtl/mem_dist_rdpipe.sv
// One read port: stage-0 capture with optional write bypass, then the latency chain.
module mem_dist_rdpipe
  import mem_dist_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned AW          = 9,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned WRITE_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ren_i,
  input  logic [AW-1:0]    raddr_i,
  input  logic [WIDTH-1:0] rword_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wmask_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rvalid_o
);

  logic [WIDTH-1:0] stage0_c;
  logic             valid_q [RD_LATENCY];
  logic [WIDTH-1:0] data_q  [RD_LATENCY];

  // Merge the in-flight write into the captured word when new data must win.
  always_comb begin
    stage0_c = rword_i;
    if ((WRITE_FIRST != 0) && wr_en_i && (waddr_i == raddr_i)) begin
      stage0_c = (rword_i & ~wmask_i) | (wdata_i & wmask_i);
    end
  end

  // Data stages only load when their valid advances, so rdata holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(RD_LATENCY); k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
      end
    end else begin
      valid_q[0] <= ren_i;
      if (ren_i) begin
        data_q[0] <= stage0_c;
      end
      for (int k = 1; k < int'(RD_LATENCY); k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) begin
          data_q[k] <= data_q[k-1];
        end
      end
    end
  end

  assign rdata_o  = data_q[RD_LATENCY-1];
  assign rvalid_o = valid_q[RD_LATENCY-1];

endmodule

// File: rtl/mem_dist_mp.sv
// Distributed-RAM scratch buffer: one byte-masked write port, NUM_RD pipelined read ports,
// and a self-zeroing init sequencer that owns the write port after reset or on request.
module mem_dist_mp
  import mem_dist_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned NUM_RD      = 2,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned BYTE_W      = 8,
  parameter int unsigned WRITE_FIRST = 0,
  localparam int unsigned AW         = clog2_min1(DEPTH),
  localparam int unsigned NB         = num_lanes(WIDTH, BYTE_W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_req,
  output logic                    init_busy,
  input  logic                    we,
  input  logic [NB-1:0]           wbe,
  input  logic [AW-1:0]           waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [NUM_RD-1:0]       ren,
  input  logic [NUM_RD*AW-1:0]    raddr,
  output logic [NUM_RD*WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]       rvalid
);

  (* ram_style = "distributed" *) logic [WIDTH-1:0] mem_q [DEPTH];

  init_state_t      state_q, state_d;
  logic [AW-1:0]    init_addr_q, init_addr_d;
  logic             init_busy_q, init_busy_d;
  logic [WIDTH-1:0] wmask_c;
  logic             user_wr_c;

  // Expand per-lane enables to a bit mask; the last lane may be partial.
  always_comb begin
    wmask_c = '0;
    for (int b = 0; b < int'(WIDTH); b++) begin
      wmask_c[b] = wbe[b / int'(BYTE_W)];
    end
  end

  assign user_wr_c = we && !init_busy_q && (32'(waddr) < DEPTH);

  // Storage has no reset; the init sequencer provides the zero contents.
  always_ff @(posedge clk) begin
    if (init_busy_q) begin
      mem_q[init_addr_q] <= '0;
    end else if (user_wr_c) begin
      mem_q[waddr] <= (mem_q[waddr] & ~wmask_c) | (wdata & wmask_c);
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    init_busy_d = init_busy_q;
    unique case (state_q)
      INIT: begin
        if (init_addr_q == AW'(DEPTH - 32'd1)) begin
          state_d     = IDLE;
          init_addr_d = '0;
          init_busy_d = 1'b0;
        end else begin
          init_addr_d = init_addr_q + AW'(1);
        end
      end
      IDLE: begin
        if (init_req) begin
          state_d     = INIT;
          init_addr_d = '0;
          init_busy_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_addr_q <= '0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      init_busy_q <= init_busy_d;
    end
  end

  assign init_busy = init_busy_q;

  // Out-of-range addresses read as zero; new reads are blocked while init owns the array.
  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
    logic [AW-1:0]    raddr_p;
    logic [WIDTH-1:0] rword_p;

    assign raddr_p = raddr[p*AW +: AW];
    assign rword_p = (32'(raddr_p) < DEPTH) ? mem_q[raddr_p] : '0;

    mem_dist_rdpipe #(
      .WIDTH       (WIDTH),
      .AW          (AW),
      .RD_LATENCY  (RD_LATENCY),
      .WRITE_FIRST (WRITE_FIRST)
    ) u_rdpipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .ren_i    (ren[p] & ~init_busy_q),
      .raddr_i  (raddr_p),
      .rword_i  (rword_p),
      .wr_en_i  (user_wr_c),
      .waddr_i  (waddr),
      .wmask_i  (wmask_c),
      .wdata_i  (wdata),
      .rdata_o  (rdata[p*WIDTH +: WIDTH]),
      .rvalid_o (rvalid[p])
    );
  end

endmodule

// File: tb/tb_mem_dist_mp.sv
// Directed bench: instance A (DEPTH 512, latency 3, read-old) and B (DEPTH 300, latency 1, write-first).
module tb_mem_dist_mp;

  localparam int unsigned AW = 9;

  logic clk;
  logic rst_n;

  logic          a_init_req, a_init_busy, a_we;
  logic [3:0]    a_wbe;
  logic [AW-1:0] a_waddr;
  logic [31:0]   a_wdata;
  logic [1:0]    a_ren, a_rvalid;
  logic [2*AW-1:0] a_raddr;
  logic [63:0]   a_rdata;

  logic          b_init_req, b_init_busy, b_we;
  logic [3:0]    b_wbe;
  logic [AW-1:0] b_waddr;
  logic [31:0]   b_wdata;
  logic [1:0]    b_ren, b_rvalid;
  logic [2*AW-1:0] b_raddr;
  logic [63:0]   b_rdata;

  int errors;
  int checks;

  mem_dist_mp #(
    .WIDTH(32), .DEPTH(512), .NUM_RD(2), .RD_LATENCY(3), .BYTE_W(8), .WRITE_FIRST(0)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .init_req(a_init_req), .init_busy(a_init_busy),
    .we(a_we), .wbe(a_wbe), .waddr(a_waddr), .wdata(a_wdata),
    .ren(a_ren), .raddr(a_raddr), .rdata(a_rdata), .rvalid(a_rvalid)
  );

  mem_dist_mp #(
    .WIDTH(32), .DEPTH(300), .NUM_RD(2), .RD_LATENCY(1), .BYTE_W(8), .WRITE_FIRST(1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .init_req(b_init_req), .init_busy(b_init_busy),
    .we(b_we), .wbe(b_wbe), .waddr(b_waddr), .wdata(b_wdata),
    .ren(b_ren), .raddr(b_raddr), .rdata(b_rdata), .rvalid(b_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [31:0]   exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int inst, input logic [AW-1:0] addr, input logic [31:0] data,
                    input logic [3:0] be);
    if (inst == 0) begin
      a_we = 1'b1; a_waddr = addr; a_wdata = data; a_wbe = be;
    end else begin
      b_we = 1'b1; b_waddr = addr; b_wdata = data; b_wbe = be;
    end
    @(negedge clk);
    a_we = 1'b0;
    b_we = 1'b0;
  endtask

  task automatic rd(input int inst, input int port, input logic [AW-1:0] addr,
                    input logic [31:0] exp, input int lat, input string name);
    int n;
    logic got;
    logic [31:0] d;
    got = 1'b0; n = 0; d = '0;
    if (inst == 0) begin
      a_ren[port] = 1'b1; a_raddr[port*AW +: AW] = addr;
    end else begin
      b_ren[port] = 1'b1; b_raddr[port*AW +: AW] = addr;
    end
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a_ren = 2'b00;
        b_ren = 2'b00;
      end
      if ((inst == 0) ? a_rvalid[port] : b_rvalid[port]) begin
        got = 1'b1;
        n = i;
        d = (inst == 0) ? a_rdata[port*32 +: 32] : b_rdata[port*32 +: 32];
      end
    end
    chk({name, "_lat"}, 128'(n), 128'(lat));
    chk(name, 128'(d), 128'(exp));
  endtask

  // Counts cycles with A busy, starting at the current negedge; also pokes init_req and we.
  task automatic measure_init(output int cnt, output logic saw_valid,
                              output logic b300, output logic b301);
    cnt = 0; saw_valid = 1'b0; b300 = 1'bx; b301 = 1'bx;
    while (a_init_busy === 1'b1 && cnt < 2000) begin
      cnt++;
      if (a_rvalid !== 2'b00) saw_valid = 1'b1;
      if (cnt == 300) b300 = b_init_busy;
      if (cnt == 301) b301 = b_init_busy;
      if (cnt == 50) a_init_req = 1'b1;
      if (cnt == 51) a_init_req = 1'b0;
      if (cnt == 200) begin
        a_we = 1'b1; a_waddr = '0; a_wdata = '1; a_wbe = '1;
      end
      if (cnt == 201) a_we = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt;
    int n;
    logic saw, b300, b301;

    errors = 0; checks = 0;
    rst_n = 1'b0;
    a_init_req = 0; a_we = 0; a_wbe = '0; a_waddr = '0; a_wdata = '0; a_ren = '0; a_raddr = '0;
    b_init_req = 0; b_we = 0; b_wbe = '0; b_waddr = '0; b_wdata = '0; b_ren = '0; b_raddr = '0;

    vecs[0] = '{4'hF, 9'd5,   32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{4'h2, 9'd5,   32'h0000AA00, 32'hDEADAAEF};
    vecs[2] = '{4'h1, 9'd5,   32'h00000011, 32'hDEADAA11};
    vecs[3] = '{4'h0, 9'd5,   32'hFFFFFFFF, 32'hDEADAA11};
    vecs[4] = '{4'hC, 9'd511, 32'hCAFE0000, 32'hCAFE0000};
    vecs[5] = '{4'hF, 9'd7,   32'h11111111, 32'h11111111};
    vecs[6] = '{4'h8, 9'd6,   32'h5A000000, 32'h5A000000};
    vecs[7] = '{4'h6, 9'd6,   32'h00123400, 32'h5A123400};

    repeat (3) @(negedge clk);
    chk("rst_busy_a", 128'(a_init_busy), 128'(1));
    chk("rst_busy_b", 128'(b_init_busy), 128'(1));
    chk("rst_outs_a", {a_rvalid, a_rdata}, 128'(0));

    // Power-up init with both ports requesting the whole time.
    a_ren = 2'b11;
    a_raddr = {9'd511, 9'd0};
    rst_n = 1'b1;
    measure_init(cnt, saw, b300, b301);
    chk("init_cycles", 128'(cnt), 128'(512));
    chk("init_no_rvalid", 128'(saw), 128'(0));
    chk("b_busy_at_300", {b300, b301}, 128'(2'b10));
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (a_rvalid == 2'b11) begin
        n = i;
        break;
      end
    end
    chk("first_rd_lat", 128'(n), 128'(3));
    chk("first_rd_zero", a_rdata, 128'(0));
    a_ren = 2'b00;
    repeat (4) @(negedge clk);

    // Byte-lane writes, read back on alternating ports.
    for (int i = 0; i < 8; i++) begin
      wr(0, vecs[i].addr, vecs[i].data, vecs[i].be);
      rd(0, i % 2, vecs[i].addr, vecs[i].exp, 3, $sformatf("vec%0d", i));
    end

    // Same-cycle write/read of addr 7 on A (old data), then the next-cycle read.
    a_we = 1'b1; a_waddr = 9'd7; a_wdata = 32'h12345678; a_wbe = 4'hF;
    a_ren = 2'b11; a_raddr = {9'd7, 9'd7};
    @(negedge clk); a_we = 1'b0;
    @(negedge clk); a_ren = 2'b00;
    @(negedge clk);
    chk("a_rdw_old", {a_rvalid, a_rdata}, {2'b11, 64'h11111111_11111111});
    @(negedge clk);
    chk("a_rdw_next", {a_rvalid, a_rdata}, {2'b11, 64'h12345678_12345678});
    @(negedge clk);
    chk("a_rdata_hold", {a_rvalid, a_rdata}, {2'b00, 64'h12345678_12345678});

    // Streaming: port 1 walks 0..7, port 0 walks 7..0.
    for (int i = 0; i < 8; i++) wr(0, AW'(i), {8'hC0, 24'(i)}, 4'hF);
    for (int t = 0; t <= 11; t++) begin
      if (t >= 3 && t <= 10)
        chk($sformatf("stream%0d", t - 3), {a_rvalid, a_rdata},
            {2'b11, 8'hC0, 24'(t - 3), 8'hC0, 24'(10 - t)});
      else if (t == 11)
        chk("stream_end", 128'(a_rvalid), 128'(0));
      if (t < 8) begin
        a_ren = 2'b11;
        a_raddr = {AW'(t), AW'(7 - t)};
      end else begin
        a_ren = 2'b00;
      end
      @(negedge clk);
    end

    // Instance B: write-first bypass, partial-lane bypass, out-of-range handling.
    chk("b_idle", 128'(b_init_busy), 128'(0));
    wr(1, 9'd7, 32'h11111111, 4'hF);
    b_we = 1'b1; b_waddr = 9'd7; b_wdata = 32'h12345678; b_wbe = 4'hF;
    b_ren = 2'b11; b_raddr = {9'd7, 9'd7};
    @(negedge clk); b_we = 1'b0;
    chk("b_rdw_new", {b_rvalid, b_rdata}, {2'b11, 64'h12345678_12345678});
    @(negedge clk); b_ren = 2'b00;
    chk("b_rdw_next", {b_rvalid, b_rdata}, {2'b11, 64'h12345678_12345678});
    @(negedge clk);
    chk("b_rvalid_pulse", 128'(b_rvalid), 128'(0));
    b_we = 1'b1; b_waddr = 9'd7; b_wdata = 32'h000000AB; b_wbe = 4'h1;
    b_ren = 2'b01; b_raddr = {9'd0, 9'd7};
    @(negedge clk); b_we = 1'b0; b_ren = 2'b00;
    chk("b_rdw_lane", {b_rvalid[0], b_rdata[31:0]}, {1'b1, 32'h123456AB});
    wr(1, 9'd54, 32'h54545454, 4'hF);
    wr(1, 9'd310, 32'hFFFFFFFF, 4'hF);
    rd(1, 0, 9'd310, 32'h0, 1, "b_oor_rd");
    rd(1, 1, 9'd54, 32'h54545454, 1, "b_alias54");

    // Re-init by request, then reset at init_addr 100 restarts the sweep.
    a_init_req = 1'b1;
    @(negedge clk); a_init_req = 1'b0;
    chk("initreq_busy", 128'(a_init_busy), 128'(1));
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {a_init_busy, a_rvalid}, 128'(3'b100));
    @(negedge clk);
    rst_n = 1'b1;
    measure_init(cnt, saw, b300, b301);
    chk("reinit_cycles", 128'(cnt), 128'(512));
    chk("reinit_no_rvalid", 128'(saw), 128'(0));
    chk("b_reinit_300", {b300, b301}, 128'(2'b10));
    rd(0, 0, 9'd5, 32'h0, 3, "post_init5");
    rd(0, 1, 9'd511, 32'h0, 3, "post_init511");
    rd(0, 0, 9'd0, 32'h0, 3, "busy_we_ignored");
    rd(0, 1, 9'd7, 32'h0, 3, "post_init7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
